// File: rtl/keypad_sum_controller.sv
// -----------------------------------------------------------------------------
// keypad_sum_controller
//
// Purpose:
//   Turns debounced hex keypad strobes into two nibble-shift operands and
//   sequences the 12-bit accumulate adder (new_input / accumulate_enable /
//   finish_input) with the cycle timing the adder expects. Also exports the
//   entry phase and the digit count of the operand being edited for the
//   display mux. No arithmetic is done here; the adder keeps the total.
//
// Ports:
//   clk                  system clock
//   rst                  asynchronous, active-high reset
//   key_valid_i          one-cycle strobe qualifying key_code_i
//   key_code_i[3:0]      0-9 digit, A '+', B '=', C clear, D backspace
//   num1_hex_o           operand A to the adder
//   num2_hex_o           operand B / accumulate operand to the adder
//   new_input_o          one-cycle pulse launching an add
//   accumulate_enable_o  level, marks the launched add as an accumulate
//   finish_input_o       one-cycle pulse returning the adder to idle
//   phase_o[1:0]         0 ENTRY_A, 1 ENTRY_B, 2 ENTRY_ACC, 3 RESULT
//   digit_count_o        digits entered into the operand being edited
//   busy_o               high while an add is issued/held; keys dropped
// -----------------------------------------------------------------------------
module keypad_sum_controller #(
    parameter int unsigned MAX_DIGITS  = 3,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 key_valid_i,
    input  logic [3:0]                           key_code_i,
    output logic [4*MAX_DIGITS-1:0]              num1_hex_o,
    output logic [4*MAX_DIGITS-1:0]              num2_hex_o,
    output logic                                 new_input_o,
    output logic                                 accumulate_enable_o,
    output logic                                 finish_input_o,
    output logic [1:0]                           phase_o,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count_o,
    output logic                                 busy_o
);

    localparam int unsigned OPW  = 4 * MAX_DIGITS;
    localparam int unsigned CNTW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned HCW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_PLUS      = 4'hA;
    localparam logic [3:0] KEY_EQUALS    = 4'hB;
    localparam logic [3:0] KEY_CLEAR     = 4'hC;
    localparam logic [3:0] KEY_BKSP      = 4'hD;

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_ENTRY_B,
        S_ENTRY_ACC,
        S_ISSUE,
        S_HOLD,
        S_RESULT
    } state_t;

    typedef enum logic [1:0] {
        PH_ENTRY_A   = 2'd0,
        PH_ENTRY_B   = 2'd1,
        PH_ENTRY_ACC = 2'd2,
        PH_RESULT    = 2'd3
    } phase_t;

    state_t            state_q,      state_d;
    phase_t            phase_q,      phase_d;
    logic [OPW-1:0]    num1_q,       num1_d;
    logic [OPW-1:0]    num2_q,       num2_d;
    logic [CNTW-1:0]   cnt_q,        cnt_d;
    logic [HCW-1:0]    hold_q,       hold_d;
    logic              acc_mode_q,   acc_mode_d;
    logic              acc_en_q,     acc_en_d;
    logic              busy_q,       busy_d;
    logic              new_input_q,  new_input_d;
    logic              finish_q,     finish_d;

    // Operand currently being edited: A in ENTRY_A, B otherwise.
    logic [OPW-1:0]    edit_val;
    logic [OPW-1:0]    edit_new;
    logic              edit_wr;
    logic              clear_req;

    // -------------------------------------------------------------------------
    // State register: every output is a flop, so all controls are computed
    // one cycle ahead in the next-state logic.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ENTRY_A;
            phase_q     <= PH_ENTRY_A;
            num1_q      <= '0;
            num2_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            acc_mode_q  <= 1'b0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            new_input_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            acc_mode_q  <= acc_mode_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            new_input_q <= new_input_d;
            finish_q    <= finish_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        acc_mode_d  = acc_mode_q;
        acc_en_d    = acc_en_q;
        busy_d      = busy_q;
        new_input_d = 1'b0;
        finish_d    = 1'b0;
        clear_req   = 1'b0;
        edit_wr     = 1'b0;
        edit_val    = (state_q == S_ENTRY_A) ? num1_q : num2_q;
        edit_new    = edit_val;

        case (state_q)
            S_ENTRY_A, S_ENTRY_B, S_ENTRY_ACC: begin
                if (key_valid_i) begin
                    if (key_code_i <= KEY_DIGIT_MAX) begin
                        // Full operand: further digits are ignored, so no
                        // nibble is ever shifted out of the top.
                        if (cnt_q < CNTW'(MAX_DIGITS)) begin
                            edit_new = (edit_val << 4) | OPW'(key_code_i);
                            edit_wr  = 1'b1;
                            cnt_d    = cnt_q + CNTW'(1);
                        end
                    end else if (key_code_i == KEY_BKSP) begin
                        if (cnt_q != '0) begin
                            edit_new = edit_val >> 4;
                            edit_wr  = 1'b1;
                            cnt_d    = cnt_q - CNTW'(1);
                        end
                    end else if (key_code_i == KEY_PLUS) begin
                        if (state_q == S_ENTRY_A) begin
                            state_d = S_ENTRY_B;
                            phase_d = PH_ENTRY_B;
                            cnt_d   = '0;
                            num2_d  = '0;
                        end
                    end else if (key_code_i == KEY_EQUALS) begin
                        // phase is left alone so the display keeps showing
                        // the entry phase that issued the add.
                        if (state_q != S_ENTRY_A) begin
                            state_d     = S_ISSUE;
                            new_input_d = 1'b1;
                            busy_d      = 1'b1;
                            hold_d      = '0;
                            acc_mode_d  = (state_q == S_ENTRY_ACC);
                            acc_en_d    = (state_q == S_ENTRY_ACC);
                        end
                    end else if (key_code_i == KEY_CLEAR) begin
                        clear_req = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (hold_q == HCW'(HOLD_CYCLES - 1)) begin
                    state_d    = S_RESULT;
                    phase_d    = PH_RESULT;
                    busy_d     = 1'b0;
                    acc_en_d   = 1'b0;
                    acc_mode_d = 1'b0;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end

            S_RESULT: begin
                if (key_valid_i) begin
                    if (key_code_i == KEY_PLUS) begin
                        state_d    = S_ENTRY_ACC;
                        phase_d    = PH_ENTRY_ACC;
                        cnt_d      = '0;
                        num2_d     = '0;
                        acc_mode_d = 1'b1;
                    end else if (key_code_i == KEY_CLEAR) begin
                        clear_req = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_ENTRY_A;
                phase_d = PH_ENTRY_A;
            end
        endcase

        if (edit_wr) begin
            if (state_q == S_ENTRY_A) begin
                num1_d = edit_new;
            end else begin
                num2_d = edit_new;
            end
        end

        // Clear is only decoded in non-busy states, so finish_input can never
        // coincide with new_input.
        if (clear_req) begin
            state_d    = S_ENTRY_A;
            phase_d    = PH_ENTRY_A;
            num1_d     = '0;
            num2_d     = '0;
            cnt_d      = '0;
            acc_mode_d = 1'b0;
            acc_en_d   = 1'b0;
            finish_d   = 1'b1;
        end
    end

    assign num1_hex_o          = num1_q;
    assign num2_hex_o          = num2_q;
    assign new_input_o         = new_input_q;
    assign accumulate_enable_o = acc_en_q;
    assign finish_input_o      = finish_q;
    assign phase_o             = phase_q;
    assign digit_count_o       = cnt_q;
    assign busy_o              = busy_q;

endmodule

// File: doc/keypad_sum_controller.md
# keypad_sum_controller

Sequences the 12-bit accumulate adder from a debounced hex keypad. Assembles keypad digits into two operands, then drives the adder's `new_input`, `accumulate_enable` and `finish_input` controls with the cycle timing the adder requires. Sits between the keypad scanner/debouncer and the adder FSM, and exports entry phase and digit count for the display mux.

## Interface
- `MAX_DIGITS`, 3: digits per operand. Operand width is 4*MAX_DIGITS = 12.
- `HOLD_CYCLES`, 2: cycles the operands are held frozen after a `new_input` pulse.

- `clk` in 1: system clock, 27 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `key_valid` in 1: one-cycle strobe that marks `key_code` valid.
- `key_code` in 4: 0x0–0x9 digit, 0xA '+', 0xB '=', 0xC clear, 0xD backspace; 0xE/0xF ignored.
- `num1_hex` out 12: operand A to the adder.
- `num2_hex` out 12: operand B or accumulate operand to the adder.
- `new_input` out 1: one-cycle pulse that launches an add.
- `accumulate_enable` out 1: level; high marks the launched add as an accumulate.
- `finish_input` out 1: one-cycle pulse that returns the adder to idle.
- `phase` out 2: 0 ENTRY_A, 1 ENTRY_B, 2 ENTRY_ACC, 3 RESULT.
- `digit_count` out 2: digits entered into the operand currently being edited.
- `busy` out 1: high during ISSUE/HOLD; keys are dropped while high.

## Operation
- States: ENTRY_A, ENTRY_B, ENTRY_ACC, ISSUE, HOLD, RESULT.
- Reset values: state ENTRY_A; all outputs 0; internal `acc_mode` 0.
- Digit key in an ENTRY state:
  - If `digit_count < MAX_DIGITS`: operand = {operand[7:0], digit} and `digit_count` +1.
  - If `digit_count = MAX_DIGITS`: key ignored.
  - ENTRY_A edits `num1_hex`; ENTRY_B and ENTRY_ACC edit `num2_hex`.
- Backspace in an ENTRY state: operand >>= 4 and count −1. Ignored when count is 0.
- '+' transitions:
  - ENTRY_A → ENTRY_B; count ← 0; `num2_hex` ← 0.
  - RESULT → ENTRY_ACC; count ← 0; `num2_hex` ← 0; `acc_mode` ← 1.
  - Ignored in ENTRY_B and ENTRY_ACC.
- '=' transitions:
  - ENTRY_B → ISSUE with `acc_mode` 0.
  - ENTRY_ACC → ISSUE with `acc_mode` 1.
  - Ignored in ENTRY_A and RESULT.
  - An empty operand (count 0) is valid and has value 0.
- ISSUE (1 cycle): `new_input` = 1; `accumulate_enable` = `acc_mode`. Next state HOLD.
- HOLD: lasts HOLD_CYCLES cycles, then RESULT. `acc_mode` and `accumulate_enable` clear on exit. Operands are frozen.
- RESULT: `num1_hex` is not modified by accumulation; the adder keeps its own running total.
- Clear (0xC):
  - From ENTRY_A, ENTRY_B, ENTRY_ACC or RESULT: `finish_input` pulses 1 cycle; `num1_hex`, `num2_hex`, count and `acc_mode` ← 0; state → ENTRY_A.
  - Ignored while `busy`.
- `phase` in ISSUE/HOLD holds the value of the ENTRY state that issued the add.
- All keys during ISSUE/HOLD are dropped, not queued.

## Timing
- All outputs are registered.
- Key strobe at edge N: the operand, count and phase update is visible after edge N+1.
- '=' at N:
  - `new_input` high for exactly cycle N+1.
  - `accumulate_enable` valid no later than cycle N+1 and held through HOLD.
  - Operands stable cycles N+1 … N+1+HOLD_CYCLES.
  - `busy` high over the same cycles.
  - RESULT from N+2+HOLD_CYCLES.
- Clear at N: `finish_input` high for cycle N+1 only.
- `new_input` and `finish_input` are never high in the same cycle.
- `rst` mid-operation (including ISSUE/HOLD) forces reset values immediately; no pulse is emitted.
- No arithmetic is performed in this block. Operands are 12-bit nibble-shift registers, and digits shifted beyond 12 bits cannot occur because of the count limit.

## Test plan
- Reset, then 10 idle cycles:
  - All outputs 0 and `phase` 0.
  - No `new_input` or `finish_input` activity.
- Keys 1,2,3,+,4,5,= ->
  - `num1_hex`=0x123 and `num2_hex`=0x045.
  - Single `new_input` pulse with `accumulate_enable`=0.
  - `busy` high for 3 cycles, then `phase`=3.
  - With the adder attached, sum_result=0x168.
- Continue with +,1,0,= ->
  - `num2_hex`=0x010.
  - `new_input` pulse with `accumulate_enable`=1 in the same cycle.
  - Adder sum_result=0x178.
  - `accumulate_enable` back to 0 in RESULT.
- Keys 1,2,3,4 in ENTRY_A -> `num1_hex`=0x123, count 3. Then backspace twice -> 0x001, count 1. Then backspace three times -> 0x000, count 0, extra backspace ignored.
- Clear during ENTRY_ACC after digit 7 ->
  - One-cycle `finish_input`.
  - Operands and count 0, `phase` 0.
  - Adder returns to idle.
- Key strobes (digit, clear, '=') during HOLD -> dropped with no state change. Separately, `rst` asserted in HOLD -> outputs 0 immediately and `phase` 0 after release.
